rssi_load_sched: RTL

Sequences the RSSI detector load strobes for a bank of receive channels in the 15.36 MHz control domain. Per-channel load pulses are issued one channel at a time, in ascending order, as a sweep. A sweep starts from one of three triggers: a free-running period timer, an external frame sync, or a software one-shot from the control register bank. The block sits in the top control hierarchy, beside the existing single-channel RSSI load logic, and is configured from register fields.

---
 rtl/rssi_load_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/rssi_load_sched.sv
// rssi_load_sched: sweeps per-channel RSSI load strobes, triggered by a period timer, a frame sync or a software request
module rssi_load_sched #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 24,
  parameter int CNT_W    = 16
) (
  input  logic                clk_15p36,
  input  logic                rst_15p36,
  input  logic                enable,
  input  logic                sync_mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          pulse_len,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                frame_sync,
  input  logic                sw_trig,
  input  logic                overrun_clr,
  output logic [NUM_CH-1:0]   rssi_load,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    sweep_cnt
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;
  state_t state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d, per_q, per_d, per_eff;
  logic [NUM_CH-1:0] mask_q, mask_d, rem, load_q, load_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [3:0] plen_q, plen_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, ovr_q, ovr_d;
  logic timer_run, expire, trig;

  function automatic logic [IW-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) lowest = IW'(i);
  endfunction

  // the period is sampled at the start of each interval so a new value lands on the next wrap
  assign timer_run = enable && !sync_mode && period != '0;
  assign per_eff   = timer_q == '0 ? period : per_q;
  assign expire    = timer_run && timer_q == per_eff - 1'b1;
  assign timer_d   = (!timer_run || expire) ? '0 : timer_q + 1'b1;
  assign per_d     = per_eff;
  assign trig      = enable && (sw_trig || (sync_mode && frame_sync) || expire);

  // sweep sequencing; outputs are derived from the next state so they come out registered
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    plen_d  = plen_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    rem     = mask_q & ~(NUM_CH'(1) << cur_q);
    case (state_q)
      IDLE: if (trig && ch_mask != '0) begin
        state_d = LOAD;
        mask_d  = ch_mask;
        cur_d   = lowest(ch_mask);
        plen_d  = pulse_len;
        pcnt_d  = '0;
      end
      LOAD: if (pcnt_q == plen_q) begin
        mask_d  = rem;
        state_d = (rem == '0 || !enable) ? IDLE : GAP;
        cnt_d   = rem == '0 ? cnt_q + 1'b1 : cnt_q;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
      GAP: begin
        state_d = enable ? LOAD : IDLE;
        cur_d   = lowest(mask_q);
        pcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    load_d = state_d == LOAD ? NUM_CH'(1) << cur_d : '0;
    busy_d = state_d != IDLE;
    ovr_d  = (trig && state_q != IDLE) ? 1'b1 : overrun_clr ? 1'b0 : ovr_q;
  end

  // state and output registers
  always_ff @(posedge clk_15p36) begin
    if (rst_15p36) begin
      state_q <= IDLE;
      timer_q <= '0;
      per_q   <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      plen_q  <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      per_q   <= per_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      plen_q  <= plen_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rssi_load = load_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign sweep_cnt = cnt_q;
endmodule
